// File: rtl/execute_pkg.sv
// Shared opcode, state and decode helpers for the EX stage with its
// iterative multiply/divide unit.
package execute_pkg;

    typedef enum logic [4:0] {
        OP_AND   = 5'b00000,
        OP_OR    = 5'b00001,
        OP_ADD   = 5'b00010,
        OP_SLLV  = 5'b00011,
        OP_SRLV  = 5'b00100,
        OP_XOR   = 5'b00101,
        OP_SUB   = 5'b00110,
        OP_SLT   = 5'b00111,
        OP_SLTU  = 5'b01000,
        OP_LUI   = 5'b01001,
        OP_SRAV  = 5'b01011,
        OP_SLL   = 5'b01100,
        OP_SRL   = 5'b01101,
        OP_SRA   = 5'b01110,
        OP_MULT  = 5'b10000,
        OP_MULTU = 5'b10001,
        OP_DIV   = 5'b10010,
        OP_DIVU  = 5'b10011,
        OP_MFHI  = 5'b10100,
        OP_MFLO  = 5'b10101,
        OP_MTHI  = 5'b10110,
        OP_MTLO  = 5'b10111
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op[4:2] == 3'b100);
    endfunction

    function automatic logic is_hilo(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// ID-to-EX bundle: decoded operands and control in, EX pipeline registers
// and the HI/LO interlock stall out.
interface execute_muldiv_if #(parameter int XLEN = 32);
    localparam int SHW = $clog2(XLEN);

    logic            flush;
    logic            AnyStall;
    logic            AluSrc_ID;
    logic            RegDst_ID;
    logic [4:0]      AluControl_ID;
    logic [XLEN-1:0] SignImm_ID;
    logic [SHW-1:0]  Shamt_ID;
    logic [XLEN-1:0] RdDatA_ID;
    logic [XLEN-1:0] RdDatB_ID;
    logic [4:0]      Rt_ID;
    logic [4:0]      Rd_ID;
    logic            RegWrite_ID;
    logic            MemWrite_ID;
    logic            MemToReg_ID;

    logic [XLEN-1:0] Result_EX;
    logic [XLEN-1:0] WrDat_EX;
    logic [4:0]      WriteReg_EX;
    logic            RegWrite_EX;
    logic            MemToReg_EX;
    logic            MemWrite_EX;
    logic            Stall_EX;

    modport master (
        output flush, AnyStall, AluSrc_ID, RegDst_ID, AluControl_ID, SignImm_ID,
               Shamt_ID, RdDatA_ID, RdDatB_ID, Rt_ID, Rd_ID, RegWrite_ID,
               MemWrite_ID, MemToReg_ID,
        input  Result_EX, WrDat_EX, WriteReg_EX, RegWrite_EX, MemToReg_EX,
               MemWrite_EX, Stall_EX
    );

    modport slave (
        input  flush, AnyStall, AluSrc_ID, RegDst_ID, AluControl_ID, SignImm_ID,
               Shamt_ID, RdDatA_ID, RdDatB_ID, Rt_ID, Rd_ID, RegWrite_ID,
               MemWrite_ID, MemToReg_ID,
        output Result_EX, WrDat_EX, WriteReg_EX, RegWrite_EX, MemToReg_EX,
               MemWrite_EX, Stall_EX
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide on operand magnitudes, owning the
// architectural HI/LO registers; signs are applied in a single FIX cycle.
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            moveTo,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int SHW = $clog2(XLEN);

    muldiv_state_t   state;
    logic [SHW-1:0]  count;
    logic [XLEN:0]   upper;
    logic [XLEN-1:0] lower;
    logic [XLEN-1:0] operandB;
    logic            isDiv, negLow, negHigh, divZero;

    logic            signA, signB;
    logic [XLEN-1:0] magA, magB;
    logic [XLEN:0]   mulSum, remShift, remDiff;
    logic            remFits;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0] fixHi, fixLo;

    // Multiply and divide share the same registers: lower starts as |A| and
    // is consumed LSB-first (multiply) or MSB-first (divide).
    always_comb begin
        signA    = !op[0] && a[XLEN-1];
        signB    = !op[0] && b[XLEN-1];
        magA     = signA ? -a : a;
        magB     = signB ? -b : b;
        mulSum   = upper + (lower[0] ? {1'b0, operandB} : '0);
        remShift = {upper[XLEN-1:0], lower[XLEN-1]};
        remFits  = (remShift >= {1'b0, operandB});
        remDiff  = remShift - {1'b0, operandB};
        product  = {upper[XLEN-1:0], lower};
        fixHi    = '0;
        fixLo    = '0;
        if (isDiv) begin
            fixLo = divZero ? '1 : (negLow ? -lower : lower);
            fixHi = negHigh ? -upper[XLEN-1:0] : upper[XLEN-1:0];
        end else begin
            {fixHi, fixLo} = negLow ? -product : product;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            upper    <= '0;
            lower    <= '0;
            operandB <= '0;
            isDiv    <= 1'b0;
            negLow   <= 1'b0;
            negHigh  <= 1'b0;
            divZero  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        upper    <= '0;
                        lower    <= magA;
                        operandB <= magB;
                        isDiv    <= op[1];
                        negLow   <= signA ^ signB;
                        negHigh  <= signA;
                        divZero  <= (b == '0);
                        count    <= '0;
                        state    <= RUN;
                    end else if (moveTo) begin
                        if (op[0]) lo <= a;
                        else       hi <= a;
                    end
                end
                RUN: begin
                    if (isDiv) begin
                        upper <= remFits ? remDiff : remShift;
                        lower <= {lower[XLEN-2:0], remFits};
                    end else begin
                        upper <= {1'b0, mulSum[XLEN:1]};
                        lower <= {mulSum[0], lower[XLEN-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == SHW'(XLEN - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= fixHi;
                    lo    <= fixLo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// EX stage: ALU, operand muxing, HI/LO interlock and EX pipeline registers
// around the iterative multiply/divide unit.
module execute_muldiv
    import execute_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic             clk,
    input logic             reset_n,
    execute_muldiv_if.slave bus
);

    logic [XLEN-1:0] srcA, srcB, aluResult, hi, lo;
    logic            busy, issue, startMd, moveTo;

    assign issue   = !bus.AnyStall && !bus.flush;
    assign startMd = issue && is_muldiv(bus.AluControl_ID);
    assign moveTo  = issue && (bus.AluControl_ID == OP_MTHI || bus.AluControl_ID == OP_MTLO);
    assign bus.Stall_EX = busy && (is_muldiv(bus.AluControl_ID) || is_hilo(bus.AluControl_ID));

    muldiv_unit #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (startMd),
        .moveTo  (moveTo),
        .op      (bus.AluControl_ID),
        .a       (srcA),
        .b       (srcB),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    // LUI places the low half of B in the upper half of the word.
    always_comb begin
        srcA      = bus.RdDatA_ID;
        srcB      = bus.AluSrc_ID ? bus.SignImm_ID : bus.RdDatB_ID;
        aluResult = '0;
        case (bus.AluControl_ID)
            OP_AND:  aluResult = srcA & srcB;
            OP_OR:   aluResult = srcA | srcB;
            OP_XOR:  aluResult = srcA ^ srcB;
            OP_ADD:  aluResult = srcA + srcB;
            OP_SUB:  aluResult = srcA - srcB;
            OP_SLT:  aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            OP_SLTU: aluResult = {{(XLEN-1){1'b0}}, (srcA < srcB)};
            OP_SLL:  aluResult = srcA << bus.Shamt_ID;
            OP_SRL:  aluResult = srcA >> bus.Shamt_ID;
            OP_SRA:  aluResult = $signed(srcA) >>> bus.Shamt_ID;
            OP_SLLV: aluResult = srcA << srcB[SHW-1:0];
            OP_SRLV: aluResult = srcA >> srcB[SHW-1:0];
            OP_SRAV: aluResult = $signed(srcA) >>> srcB[SHW-1:0];
            OP_LUI:  aluResult = srcB << (XLEN / 2);
            OP_MFHI: aluResult = hi;
            OP_MFLO: aluResult = lo;
            default: aluResult = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.Result_EX   <= '0;
            bus.WrDat_EX    <= '0;
            bus.WriteReg_EX <= '0;
            bus.RegWrite_EX <= 1'b0;
            bus.MemToReg_EX <= 1'b0;
            bus.MemWrite_EX <= 1'b0;
        end else if (bus.flush) begin
            bus.Result_EX   <= '0;
            bus.WrDat_EX    <= '0;
            bus.WriteReg_EX <= '0;
            bus.RegWrite_EX <= 1'b0;
            bus.MemToReg_EX <= 1'b0;
            bus.MemWrite_EX <= 1'b0;
        end else if (!bus.AnyStall) begin
            bus.Result_EX   <= aluResult;
            bus.WrDat_EX    <= bus.RdDatB_ID;
            bus.WriteReg_EX <= bus.RegDst_ID ? bus.Rd_ID : bus.Rt_ID;
            bus.RegWrite_EX <= bus.RegWrite_ID;
            bus.MemToReg_EX <= bus.MemToReg_ID;
            bus.MemWrite_EX <= bus.MemWrite_ID;
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: ALU ops, mul/div through MFHI/MFLO,
// stall/flush behaviour and reset abort, checked against a result queue.
module tb_execute_muldiv;
    import execute_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    logic clk      = 1'b0;
    logic reset_n  = 1'b1;
    logic extStall = 1'b0;

    expect_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    execute_muldiv_if #(.XLEN(XLEN)) bus ();

    assign bus.AnyStall = extStall | bus.Stall_EX;

    execute_muldiv #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.flush         = 1'b0;
        bus.AluSrc_ID     = 1'b0;
        bus.RegDst_ID     = 1'b0;
        bus.AluControl_ID = OP_AND;
        bus.SignImm_ID    = '0;
        bus.Shamt_ID      = '0;
        bus.RdDatA_ID     = '0;
        bus.RdDatB_ID     = '0;
        bus.Rt_ID         = '0;
        bus.Rd_ID         = '0;
        bus.RegWrite_ID   = 1'b0;
        bus.MemWrite_ID   = 1'b0;
        bus.MemToReg_ID   = 1'b0;
    endtask

    task automatic driveOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] shamt);
        bus.AluControl_ID = op;
        bus.RdDatA_ID     = a;
        bus.RdDatB_ID     = b;
        bus.Shamt_ID      = shamt;
        bus.AluSrc_ID     = 1'b0;
        bus.SignImm_ID    = '0;
        bus.RegDst_ID     = 1'b1;
        bus.Rt_ID         = 5'd7;
        bus.Rd_ID         = 5'd9;
        bus.RegWrite_ID   = !is_muldiv(op);
        bus.MemWrite_ID   = 1'b0;
        bus.MemToReg_ID   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] shamt, input string tag, input logic [31:0] exp);
        expect_t e;
        driveOp(op, a, b, shamt);
        e.tag   = tag;
        e.value = exp;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: observed=0x%08h expected=<none queued>", bus.Result_EX);
        end else begin
            e = sb.pop_front();
            checkVal(e.tag, bus.Result_EX, e.value);
        end
    endtask

    task automatic aluCase(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] shamt, input string tag, input logic [31:0] exp);
        applyStimulus(op, a, b, shamt, tag, exp);
        step();
        checkOutput();
    endtask

    // MFHI waits out the interlock (bounded), then MFLO follows.
    task automatic readHiLo(input logic [31:0] expHi, input logic [31:0] expLo,
                            input string tag, input int expCycles);
        int n;
        applyStimulus(OP_MFHI, 32'h0, 32'h0, 5'd0, {tag, " HI"}, expHi);
        #1;
        n = 0;
        while (bus.Stall_EX !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        checkVal({tag, " stall cycles"}, 32'(n), 32'(expCycles));
        step();
        checkOutput();
        applyStimulus(OP_MFLO, 32'h0, 32'h0, 5'd0, {tag, " LO"}, expLo);
        step();
        checkOutput();
    endtask

    task automatic mulDivCase(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] expHi, input logic [31:0] expLo, input string tag);
        driveOp(op, a, b, 5'd0);
        step();
        readHiLo(expHi, expLo, tag, 33);
    endtask

    function automatic void modelMulDiv(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic [31:0] hi,
                                        output logic [31:0] lo);
        logic [63:0] p;
        longint q, r;
        p = '0;
        case (op)
            OP_MULT:  p = 64'(longint'($signed(a)) * longint'($signed(b)));
            OP_MULTU: p = {32'h0, a} * {32'h0, b};
            OP_DIV: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    p = {32'(r), 32'(q)};
                end
            end
            OP_DIVU: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    initial begin
        logic [31:0] mHi, mLo;

        clearInputs();
        #1 reset_n = 1'b0;
        #10;
        checkVal("reset Result_EX", bus.Result_EX, 32'h0);
        checkVal("reset RegWrite_EX", 32'(bus.RegWrite_EX), 32'h0);
        checkVal("reset Stall_EX", 32'(bus.Stall_EX), 32'h0);
        reset_n = 1'b1;
        step();

        aluCase(OP_SRA,  32'h8000_0000, 32'h8000_0000, 5'd4,  "SRA",  32'hF800_0000);
        aluCase(OP_SRL,  32'h8000_0000, 32'h8000_0000, 5'd4,  "SRL",  32'h0800_0000);
        aluCase(OP_SLL,  32'h0000_0001, 32'h0000_0001, 5'd31, "SLL",  32'h8000_0000);
        aluCase(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  "SLT",  32'h0000_0001);
        aluCase(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  "SLTU", 32'h0000_0000);
        aluCase(OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 5'd0,  "SLT ovf", 32'h0000_0000);
        aluCase(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  "ADD",  32'h8000_0000);
        aluCase(OP_SUB,  32'h0000_0005, 32'h0000_0007, 5'd0,  "SUB",  32'hFFFF_FFFE);
        aluCase(OP_AND,  32'hF0F0_1234, 32'hFF00_FF00, 5'd0,  "AND",  32'hF000_1200);
        aluCase(OP_OR,   32'hF0F0_1234, 32'h0F00_0001, 5'd0,  "OR",   32'hFFF0_1235);
        aluCase(OP_XOR,  32'hFFFF_0000, 32'hF0F0_F0F0, 5'd0,  "XOR",  32'h0F0F_F0F0);
        aluCase(OP_SRLV, 32'hF000_0000, 32'h0000_0004, 5'd0,  "SRLV", 32'h0F00_0000);
        aluCase(OP_SRAV, 32'h8000_0000, 32'h0000_0021, 5'd0,  "SRAV", 32'hC000_0000);
        aluCase(OP_SLLV, 32'h0000_0003, 32'h0000_0008, 5'd0,  "SLLV", 32'h0000_0300);
        aluCase(5'b01010, 32'h1234_5678, 32'h1111_1111, 5'd0, "undefined op", 32'h0);

        applyStimulus(OP_LUI, 32'hDEAD_BEEF, 32'h0000_5555, 5'd0, "LUI", 32'h1234_0000);
        bus.AluSrc_ID  = 1'b1;
        bus.SignImm_ID = 32'h0000_1234;
        step();
        checkOutput();
        checkVal("RegDst=1 WriteReg_EX", 32'(bus.WriteReg_EX), 32'd9);

        driveOp(OP_ADD, 32'h1, 32'hCAFE_F00D, 5'd0);
        bus.RegDst_ID   = 1'b0;
        bus.RegWrite_ID = 1'b0;
        bus.MemWrite_ID = 1'b1;
        bus.MemToReg_ID = 1'b0;
        step();
        checkVal("MemWrite_EX", 32'(bus.MemWrite_EX), 32'h1);
        checkVal("MemToReg_EX", 32'(bus.MemToReg_EX), 32'h0);
        checkVal("RegWrite_EX off", 32'(bus.RegWrite_EX), 32'h0);
        checkVal("WriteReg_EX Rt", 32'(bus.WriteReg_EX), 32'd7);
        checkVal("WrDat_EX", bus.WrDat_EX, 32'hCAFE_F00D);
        bus.MemWrite_ID = 1'b0;
        bus.MemToReg_ID = 1'b1;
        step();
        checkVal("MemWrite_EX off", 32'(bus.MemWrite_EX), 32'h0);
        checkVal("MemToReg_EX on", 32'(bus.MemToReg_EX), 32'h1);

        aluCase(OP_ADD, 32'h5, 32'h6, 5'd0, "ADD before hold", 32'hB);
        extStall = 1'b1;
        driveOp(OP_SUB, 32'd100, 32'd1, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("hold Result_EX", bus.Result_EX, 32'hB);
        end
        checkVal("hold RegWrite_EX", 32'(bus.RegWrite_EX), 32'h1);
        bus.flush = 1'b1;
        step();
        checkVal("flush Result_EX", bus.Result_EX, 32'h0);
        checkVal("flush RegWrite_EX", 32'(bus.RegWrite_EX), 32'h0);
        checkVal("flush WriteReg_EX", 32'(bus.WriteReg_EX), 32'h0);
        bus.flush = 1'b0;
        extStall  = 1'b0;

        mulDivCase(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULT");
        mulDivCase(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "MULTU");
        mulDivCase(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "DIVU");
        mulDivCase(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "DIV neg");
        mulDivCase(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "DIV minneg");
        modelMulDiv(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, mHi, mLo);
        mulDivCase(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, mHi, mLo, "MULT model");
        modelMulDiv(OP_DIV, 32'h8000_0001, 32'h0000_0013, mHi, mLo);
        mulDivCase(OP_DIV, 32'h8000_0001, 32'h0000_0013, mHi, mLo, "DIV model");

        driveOp(OP_MTHI, 32'hA5A5_A5A5, 32'h0, 5'd0);
        step();
        driveOp(OP_MTLO, 32'h5A5A_5A5A, 32'h0, 5'd0);
        step();
        readHiLo(32'hA5A5_A5A5, 32'h5A5A_5A5A, "MTHI/MTLO", 0);

        driveOp(OP_DIVU, 32'd5, 32'd0, 5'd0);
        step();
        applyStimulus(OP_ADD, 32'd3, 32'd4, 5'd0, "ADD during busy", 32'd7);
        #1;
        checkVal("ADD not stalled", 32'(bus.Stall_EX), 32'h0);
        step();
        checkOutput();
        readHiLo(32'd5, 32'hFFFF_FFFF, "DIVU by zero", 32);

        driveOp(OP_DIV, 32'd50, 32'd3, 5'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        readHiLo(32'd5, 32'hFFFF_FFFF, "flush start", 0);

        driveOp(OP_DIV, 32'd1000, 32'd3, 5'd0);
        step();
        driveOp(OP_ADD, 32'h10, 32'h20, 5'd0);
        repeat (9) step();
        checkVal("pre-reset Result_EX", bus.Result_EX, 32'h30);
        driveOp(OP_MFHI, 32'h0, 32'h0, 5'd0);
        #1;
        checkVal("pre-reset Stall_EX", 32'(bus.Stall_EX), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        checkVal("async reset Result_EX", bus.Result_EX, 32'h0);
        checkVal("async reset RegWrite_EX", 32'(bus.RegWrite_EX), 32'h0);
        checkVal("async reset Stall_EX", 32'(bus.Stall_EX), 32'h0);
        reset_n = 1'b1;
        readHiLo(32'h0, 32'h0, "after reset", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
